spi_command_decoder: RTL and testbench

Sits directly downstream of the SPI secondary shifter and consumes its received-word strobe and byte. Parses the byte stream into framed motion commands: SYNC, CMD, LEN, payload, checksum. Validated frames go into a small command FIFO that the motion core drains over a valid/ready handshake. Drives back to the shifter the status byte to be shifted out on the next SPI word.

---
 rtl/spi_command_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_command_decoder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_decoder.sv
// spi_command_decoder: frames the SPI byte stream into motion commands
// (SYNC, CMD, LEN, payload, checksum), queues validated frames in a small
// command FIFO and returns a registered status byte to the SPI shifter.
// Optional build macro: SPI_CMD_DECODER_CRC8_EN selects CRC-8 (poly 0x07)
// as the frame checksum instead of the default 8-bit XOR.
module spi_command_decoder #(
  parameter int unsigned WordBits   = 8,
  parameter int unsigned MaxPayload = 8,
  parameter int unsigned FifoDepth  = 4,
  parameter logic [7:0]  SyncByte   = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    word_ready,
  input  logic [WordBits-1:0]     data_word_received,
  input  logic                    cs,
  output logic [WordBits-1:0]     data_word_to_send,
  input  logic                    err_clear,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_opcode,
  output logic [3:0]              cmd_len,
  output logic [8*MaxPayload-1:0] cmd_payload
);

  localparam int unsigned PayW = 8 * MaxPayload;
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = 3;
  localparam int unsigned IdxW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  // One-byte checksum step; a CMD byte is folded into a zero seed.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
`ifdef SPI_CMD_DECODER_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
`else
    return acc ^ b;
`endif
  endfunction

  // Pointer increment wrapping modulo FifoDepth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : PtrW'(p + 1'b1);
  endfunction

  logic [7:0]      rx_byte;
  state_t          state_q, state_d;
  logic [7:0]      opcode_q;
  logic [3:0]      len_q;
  logic [7:0]      chk_q;
  logic [IdxW-1:0] idx_q;
  logic [PayW-1:0] staging_q;
  logic            len_err_c, chk_err_c, frame_ok_c;

  logic [7:0]      fifo_op  [FifoDepth];
  logic [3:0]      fifo_len [FifoDepth];
  logic [PayW-1:0] fifo_pay [FifoDepth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_c, pop_c, push_c, ovf_c;
  logic [7:0]      head_op_d;
  logic [3:0]      head_len_d;
  logic [PayW-1:0] head_pay_d;
  logic            err_len_q, err_chk_q, err_ovf_q;
  logic            err_len_d, err_chk_d, err_ovf_d;
  logic [7:0]      status_d;

  assign rx_byte = 8'(data_word_received);

  // Parser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Parser next state and per-strobe frame events; cs overrides everything.
  always_comb begin
    state_d    = state_q;
    len_err_c  = 1'b0;
    chk_err_c  = 1'b0;
    frame_ok_c = 1'b0;
    if (cs) begin
      state_d = S_IDLE;
    end else if (word_ready) begin
      case (state_q)
        S_IDLE: if (rx_byte == SyncByte) state_d = S_CMD;
        S_CMD:  state_d = S_LEN;
        S_LEN: begin
          if (rx_byte > 8'(MaxPayload)) begin
            len_err_c = 1'b1;
            state_d   = S_IDLE;
          end else if (rx_byte == 8'h00) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (idx_q == IdxW'(len_q - 4'd1)) state_d = S_CHECK;
        S_CHECK: begin
          if (rx_byte != chk_q) chk_err_c  = 1'b1;
          else                  frame_ok_c = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Frame staging: opcode, length, running checksum and payload bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
    end else if (cs) begin
      staging_q <= '0;
      idx_q     <= '0;
    end else if (word_ready) begin
      case (state_q)
        S_CMD: begin
          opcode_q <= rx_byte;
          chk_q    <= chk_update(8'h00, rx_byte);
        end
        S_LEN: begin
          if (rx_byte <= 8'(MaxPayload)) begin
            len_q     <= rx_byte[3:0];
            chk_q     <= chk_update(chk_q, rx_byte);
            staging_q <= '0;
            idx_q     <= '0;
          end
        end
        S_PAYLOAD: begin
          for (int i = 0; i < int'(MaxPayload); i++) begin
            if (idx_q == IdxW'(i)) staging_q[8*i +: 8] <= rx_byte;
          end
          chk_q <= chk_update(chk_q, rx_byte);
          idx_q <= IdxW'(idx_q + 1'b1);
        end
        default: ;
      endcase
    end
  end

  // FIFO bookkeeping, next head contents, sticky errors and status byte.
  always_comb begin
    full_c   = (count_q == CntW'(FifoDepth));
    pop_c    = cmd_valid & cmd_ready;
    push_c   = frame_ok_c & (~full_c | pop_c);
    ovf_c    = frame_ok_c & full_c & ~pop_c;
    count_d  = CntW'(count_q + CntW'(push_c) - CntW'(pop_c));
    rd_ptr_d = pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    head_op_d  = '0;
    head_len_d = '0;
    head_pay_d = '0;
    if (count_d != '0) begin
      if (push_c && (CntW'(count_q - CntW'(pop_c)) == '0)) begin
        head_op_d  = opcode_q;
        head_len_d = len_q;
        head_pay_d = staging_q;
      end else begin
        head_op_d  = fifo_op[rd_ptr_d];
        head_len_d = fifo_len[rd_ptr_d];
        head_pay_d = fifo_pay[rd_ptr_d];
      end
    end

    err_len_d = len_err_c | (err_len_q & ~err_clear);
    err_chk_d = chk_err_c | (err_chk_q & ~err_clear);
    err_ovf_d = ovf_c     | (err_ovf_q & ~err_clear);
    status_d  = {(count_d == CntW'(FifoDepth)), (count_d == '0),
                 err_len_d, err_chk_d, err_ovf_d, count_d};
  end

  // FIFO storage; entries are only read while they hold a valid command.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_op[wr_ptr_q]  <= opcode_q;
      fifo_len[wr_ptr_q] <= len_q;
      fifo_pay[wr_ptr_q] <= staging_q;
    end
  end

  // Pointers, occupancy, errors and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      count_q           <= '0;
      err_len_q         <= 1'b0;
      err_chk_q         <= 1'b0;
      err_ovf_q         <= 1'b0;
      cmd_valid         <= 1'b0;
      cmd_opcode        <= '0;
      cmd_len           <= '0;
      cmd_payload       <= '0;
      data_word_to_send <= WordBits'(8'h40);
    end else begin
      rd_ptr_q          <= rd_ptr_d;
      wr_ptr_q          <= wr_ptr_d;
      count_q           <= count_d;
      err_len_q         <= err_len_d;
      err_chk_q         <= err_chk_d;
      err_ovf_q         <= err_ovf_d;
      cmd_valid         <= (count_d != '0);
      cmd_opcode        <= head_op_d;
      cmd_len           <= head_len_d;
      cmd_payload       <= head_pay_d;
      data_word_to_send <= WordBits'(status_d);
    end
  end

endmodule

// File: tb/tb_spi_command_decoder.sv
// Bench for spi_command_decoder: directed frames plus randomized traffic
// checked against a queue-based model of the framing rules.
module tb_spi_command_decoder;

  localparam int unsigned MaxP  = 8;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n, word_ready, cs, err_clear, cmd_ready;
  logic [7:0]  data_word_received, data_word_to_send;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_command_decoder #(
    .WordBits(8), .MaxPayload(MaxP), .FifoDepth(Depth), .SyncByte(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .word_ready(word_ready),
    .data_word_received(data_word_received), .cs(cs),
    .data_word_to_send(data_word_to_send), .err_clear(err_clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload)
  );

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  len;
    logic [63:0] pay;
  } ent_t;

  ent_t mq[$];
  bit   m_len, m_chk, m_ovf;

  // Reference checksum over the message bits, MSB first.
  function automatic logic [7:0] ref_sum(input logic [7:0] msg[$]);
    logic [7:0] s;
    logic       fb;
    s = 8'h00;
    foreach (msg[k]) begin
`ifdef SPI_CMD_DECODER_CRC8_EN
      for (int bi = 7; bi >= 0; bi--) begin
        fb = s[7] ^ msg[k][bi];
        s  = {s[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
`else
      fb = 1'b0;
      s  = s ^ msg[k];
`endif
    end
    return s;
  endfunction

  function automatic logic [7:0] exp_status();
    return {(mq.size() == Depth), (mq.size() == 0), m_len, m_chk, m_ovf, 3'(mq.size())};
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    data_word_received = b;
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    cmd_ready  = 1'b0;
    err_clear  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Drives a whole frame and applies the framing rules to the model.
  task automatic send_frame(input logic [7:0] op, input logic [7:0] lenb,
                            input logic [63:0] pay, input bit bad,
                            input bit pop_last, input bit clr_last, input int gap);
    logic [7:0] msg[$];
    logic [7:0] last;
    ent_t       e;
    bit         popped;
    send_byte(8'hA5, gap);
    send_byte(op, gap);
    if (lenb > MaxP) begin
      last = lenb;
    end else begin
      send_byte(lenb, gap);
      msg.push_back(op);
      msg.push_back(lenb);
      for (int i = 0; i < int'(lenb); i++) begin
        msg.push_back(pay[8*i +: 8]);
        if (i < int'(lenb) - 1) send_byte(pay[8*i +: 8], gap);
      end
      if (lenb != 0) last = pay[8*(int'(lenb)-1) +: 8];
      else           last = 8'h00;
      if (lenb != 0) send_byte(last, gap);
      last = ref_sum(msg) ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
    end
    cmd_ready = pop_last;
    err_clear = clr_last;
    popped    = pop_last && (mq.size() > 0);
    send_byte(last, gap);
    if (popped) void'(mq.pop_front());
    if (clr_last) begin m_len = 0; m_chk = 0; m_ovf = 0; end
    if (lenb > MaxP)             m_len = 1;
    else if (bad)                m_chk = 1;
    else if (mq.size() == Depth) m_ovf = 1;
    else begin
      e.op  = op;
      e.len = lenb[3:0];
      e.pay = '0;
      for (int i = 0; i < int'(lenb); i++) e.pay[8*i +: 8] = pay[8*i +: 8];
      mq.push_back(e);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; word_ready = 1'b0; cs = 1'b0; err_clear = 1'b0; cmd_ready = 1'b0;
    data_word_received = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete(); m_len = 0; m_chk = 0; m_ovf = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (data_word_to_send !== 8'h40) begin
      n_errors++; $display("FAIL reset_status: got %h expected 40", data_word_to_send);
    end
    n_checks++;
    if ({cmd_valid, cmd_opcode, cmd_len, cmd_payload} !== 77'd0) begin
      n_errors++; $display("FAIL reset_head: got v=%b op=%h len=%h pay=%h expected all zero",
                           cmd_valid, cmd_opcode, cmd_len, cmd_payload);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] msg[$];
    apply_reset();
    msg = {8'h10, 8'h02, 8'h11, 8'h22};
    foreach (msg[k]) send_byte(msg[k], 0);
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_errors++; $display("FAIL basic_early_valid: got %b expected 0", cmd_valid);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0); send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(ref_sum(msg), 0);
    n_checks++;
    if ({cmd_valid, cmd_opcode, cmd_len, cmd_payload} !== {1'b1, 8'h10, 4'd2, 64'h2211}) begin
      n_errors++; $display("FAIL basic_head: got v=%b op=%h len=%0d pay=%h expected v=1 op=10 len=2 pay=2211",
                           cmd_valid, cmd_opcode, cmd_len, cmd_payload);
    end
    n_checks++;
    if (data_word_to_send !== 8'h01) begin
      n_errors++; $display("FAIL basic_status: got %h expected 01", data_word_to_send);
    end
  endtask

  task automatic test_len_err();
    apply_reset();
    send_frame(8'h10, 8'h09, 64'h0, 0, 0, 0, 1);
    send_frame(8'h20, 8'h00, 64'h0, 0, 0, 0, 1);
    n_checks++;
    if (data_word_to_send !== 8'h21) begin
      n_errors++; $display("FAIL lenerr_status: got %h expected 21", data_word_to_send);
    end
    n_checks++;
    if ({cmd_valid, cmd_opcode, cmd_len, cmd_payload} !== {1'b1, 8'h20, 4'd0, 64'h0}) begin
      n_errors++; $display("FAIL lenerr_head: got v=%b op=%h len=%0d pay=%h expected v=1 op=20 len=0 pay=0",
                           cmd_valid, cmd_opcode, cmd_len, cmd_payload);
    end
  endtask

  task automatic test_chk_err();
    apply_reset();
    send_frame(8'h10, 8'h01, 64'h33, 1, 0, 0, 0);
    n_checks++;
    if ({cmd_valid, data_word_to_send} !== {1'b0, 8'h50}) begin
      n_errors++; $display("FAIL chkerr_status: got v=%b st=%h expected v=0 st=50", cmd_valid, data_word_to_send);
    end
    err_clear = 1'b1; @(posedge clk); #1; err_clear = 1'b0;
    m_chk = 0;
    n_checks++;
    if (data_word_to_send !== 8'h40) begin
      n_errors++; $display("FAIL chkerr_clear: got %h expected 40", data_word_to_send);
    end
    // err_clear on the same strobe as a failing checksum: the set wins.
    send_frame(8'h10, 8'h01, 64'h33, 1, 0, 1, 0);
    n_checks++;
    if (data_word_to_send !== 8'h50) begin
      n_errors++; $display("FAIL chkerr_set_wins: got %h expected 50", data_word_to_send);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 8'h00, 64'h0, 0, 0, 0, 1);
    n_checks++;
    if (data_word_to_send !== 8'h8C) begin
      n_errors++; $display("FAIL ovf_status: got %h expected 8c", data_word_to_send);
    end
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if ({cmd_valid, cmd_opcode} !== {1'b1, 8'(k)}) begin
        n_errors++; $display("FAIL ovf_pop_order: got v=%b op=%h expected v=1 op=%h", cmd_valid, cmd_opcode, 8'(k));
      end
      cmd_ready = 1'b1; @(posedge clk); #1; cmd_ready = 1'b0;
      void'(mq.pop_front());
    end
    n_checks++;
    if ({cmd_valid, data_word_to_send} !== {1'b0, 8'h48}) begin
      n_errors++; $display("FAIL ovf_drained: got v=%b st=%h expected v=0 st=48", cmd_valid, data_word_to_send);
    end
  endtask

  task automatic test_cs_abort();
    apply_reset();
    send_byte(8'hA5, 0); send_byte(8'h10, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    cs = 1'b1; @(posedge clk); #1; cs = 1'b0;
    send_frame(8'h30, 8'h00, 64'h0, 0, 0, 0, 0);
    // A strobe coincident with cs must be ignored, even an oversize LEN.
    send_byte(8'hA5, 0); send_byte(8'h50, 0);
    cs = 1'b1; send_byte(8'h09, 0); cs = 1'b0;
    send_byte(8'h00, 0); send_byte(8'h50, 0);
    n_checks++;
    if (data_word_to_send !== 8'h01) begin
      n_errors++; $display("FAIL cs_status: got %h expected 01", data_word_to_send);
    end
    n_checks++;
    if ({cmd_valid, cmd_opcode, cmd_len} !== {1'b1, 8'h30, 4'd0}) begin
      n_errors++; $display("FAIL cs_head: got v=%b op=%h len=%0d expected v=1 op=30 len=0", cmd_valid, cmd_opcode, cmd_len);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_frame(8'hB1, 8'h01, 64'h77, 0, 0, 0, 0);
    send_frame(8'hB2, 8'h02, 64'hBEEF, 0, 1, 0, 0);
    n_checks++;
    if ({cmd_valid, cmd_opcode, cmd_len, cmd_payload, data_word_to_send} !==
        {1'b1, mq[0].op, mq[0].len, mq[0].pay, exp_status()}) begin
      n_errors++; $display("FAIL b2b_single: got op=%h st=%h expected op=%h st=%h",
                           cmd_opcode, data_word_to_send, mq[0].op, exp_status());
    end
    for (int k = 0; k < 3; k++) send_frame(8'hC0 + 8'(k), 8'h01, 64'(k), 0, 0, 0, 0);
    send_frame(8'hD0, 8'h03, 64'h123456, 0, 1, 0, 0);
    n_checks++;
    if (data_word_to_send !== 8'h84) begin
      n_errors++; $display("FAIL b2b_full_status: got %h expected 84", data_word_to_send);
    end
    n_checks++;
    if ({cmd_valid, cmd_opcode, cmd_len, cmd_payload} !== {1'b1, mq[0].op, mq[0].len, mq[0].pay}) begin
      n_errors++; $display("FAIL b2b_full_head: got op=%h expected op=%h", cmd_opcode, mq[0].op);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_frame(8'h60, 8'h01, 64'h5A, 0, 0, 0, 0);
    send_byte(8'hA5, 0); send_byte(8'h10, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_valid, cmd_opcode, cmd_len, cmd_payload, data_word_to_send} !== {77'd0, 8'h40}) begin
      n_errors++; $display("FAIL midreset_outputs: got v=%b op=%h len=%h st=%h expected zeros st=40",
                           cmd_valid, cmd_opcode, cmd_len, data_word_to_send);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    mq.delete(); m_len = 0; m_chk = 0; m_ovf = 0;
    @(posedge clk); #1;
    send_frame(8'h40, 8'h00, 64'h0, 0, 0, 0, 0);
    n_checks++;
    if ({cmd_valid, cmd_opcode, data_word_to_send} !== {1'b1, 8'h40, 8'h01}) begin
      n_errors++; $display("FAIL midreset_next: got v=%b op=%h st=%h expected v=1 op=40 st=01",
                           cmd_valid, cmd_opcode, data_word_to_send);
    end
  endtask

  task automatic test_random();
    logic [7:0]  junk, lenb;
    logic [63:0] pay;
    int          npop;
    apply_reset();
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, $urandom_range(0, 2));
      end
      if ($urandom_range(0, 7) == 0) begin
        send_byte(8'hA5, 0); send_byte(8'($urandom), 0);
        cs = 1'b1; @(posedge clk); #1; cs = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) begin
        err_clear = 1'b1; @(posedge clk); #1; err_clear = 1'b0;
        m_len = 0; m_chk = 0; m_ovf = 0;
      end
      lenb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(9, 15)) : 8'($urandom_range(0, 8));
      pay  = {$urandom, $urandom};
      send_frame(8'($urandom), lenb, pay, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
      n_checks++;
      if (data_word_to_send !== exp_status()) begin
        n_errors++; $display("FAIL rand_status frame %0d: got %h expected %h", f, data_word_to_send, exp_status());
      end
      n_checks++;
      if (mq.size() == 0) begin
        if (cmd_valid !== 1'b0) begin
          n_errors++; $display("FAIL rand_head frame %0d: got v=%b expected v=0", f, cmd_valid);
        end
      end else if ({cmd_valid, cmd_opcode, cmd_len, cmd_payload} !== {1'b1, mq[0].op, mq[0].len, mq[0].pay}) begin
        n_errors++; $display("FAIL rand_head frame %0d: got v=%b op=%h len=%0d pay=%h expected op=%h len=%0d pay=%h",
                             f, cmd_valid, cmd_opcode, cmd_len, cmd_payload, mq[0].op, mq[0].len, mq[0].pay);
      end
      if (mq.size() == Depth || $urandom_range(0, 3) == 0) begin
        npop = $urandom_range(1, mq.size() + 1);
        for (int p = 0; p < npop && mq.size() > 0; p++) begin
          n_checks++;
          if ({cmd_valid, cmd_opcode, cmd_len, cmd_payload} !== {1'b1, mq[0].op, mq[0].len, mq[0].pay}) begin
            n_errors++; $display("FAIL rand_pop frame %0d: got v=%b op=%h len=%0d expected op=%h len=%0d",
                                 f, cmd_valid, cmd_opcode, cmd_len, mq[0].op, mq[0].len);
          end
          cmd_ready = 1'b1; @(posedge clk); #1; cmd_ready = 1'b0;
          void'(mq.pop_front());
        end
        n_checks++;
        if (data_word_to_send !== exp_status()) begin
          n_errors++; $display("FAIL rand_drain_status frame %0d: got %h expected %h", f, data_word_to_send, exp_status());
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; word_ready = 1'b0; cs = 1'b0; err_clear = 1'b0; cmd_ready = 1'b0;
    data_word_received = 8'h00;
    test_reset();
    test_basic_frame();
    test_len_err();
    test_chk_err();
    test_overflow();
    test_cs_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
